// File: rtl/tile_sequencer_hybrid_if.sv
// Signal bundle between the tile sequencer and its host, weight loader, DRAM port and tile engine.
// The master modport is the sequencer side; slave is the environment side.
interface tile_sequencer_hybrid_if #(
   parameter int ADDR_W    = 32,
   parameter int MAX_TILES = 16,
   parameter int WSETS     = 8,
   parameter int CNT_W     = 16
);
   localparam int NT_W = $clog2(MAX_TILES + 1);
   localparam int WS_W = (WSETS > 1) ? $clog2(WSETS) : 1;

   // host command side
   logic              start;
   logic [NT_W-1:0]   num_tiles_cfg;
   logic [ADDR_W-1:0] in_base;
   logic [ADDR_W-1:0] out_base;
   logic              busy;
   logic              done;
   logic              err_timeout;
   logic [NT_W-1:0]   tiles_completed;

   // weight loader
   logic              load_weights;
   logic [WS_W-1:0]   weight_set;
   logic              weights_ready;

   // DRAM port
   logic              dram_rd_en;
   logic [ADDR_W-1:0] dram_rd_addr;
   logic              dram_rd_ready;
   logic              dram_wr_en;
   logic [ADDR_W-1:0] dram_wr_addr;
   logic              dram_wr_ready;
   logic              accumulate_en;

   // tile engine
   logic              tile_start;
   logic              tile_done;
   logic [CNT_W-1:0]  zero_ops_skipped;
   logic [CNT_W-1:0]  total_ops_executed;
   logic              overflow_detected;
   logic [1:0]        precision_mode;
   logic              sparsity_optimize_en;

   modport master (
      input  start, num_tiles_cfg, in_base, out_base,
      output busy, done, err_timeout, tiles_completed,
      output load_weights, weight_set,
      input  weights_ready,
      output dram_rd_en, dram_rd_addr,
      input  dram_rd_ready,
      output dram_wr_en, dram_wr_addr, accumulate_en,
      input  dram_wr_ready,
      output tile_start,
      input  tile_done, zero_ops_skipped, total_ops_executed, overflow_detected,
      output precision_mode, sparsity_optimize_en
   );

   modport slave (
      output start, num_tiles_cfg, in_base, out_base,
      input  busy, done, err_timeout, tiles_completed,
      input  load_weights, weight_set,
      output weights_ready,
      input  dram_rd_en, dram_rd_addr,
      output dram_rd_ready,
      input  dram_wr_en, dram_wr_addr, accumulate_en,
      output dram_wr_ready,
      input  tile_start,
      output tile_done, zero_ops_skipped, total_ops_executed, overflow_detected,
      input  precision_mode, sparsity_optimize_en
   );
endinterface

// File: rtl/tile_sequencer_hybrid.sv
// Multi-tile run controller: weight load, input fetch, tile launch, write-back/accumulate,
// with per-tile precision escalation and sparsity-mode hysteresis.
module tile_sequencer_hybrid #(
   parameter int          ADDR_W      = 32,
   parameter int          MAX_TILES   = 16,
   parameter logic [31:0] TILE_STRIDE = 32'h400,
   parameter int          WSETS       = 8,
   parameter int          ACC_GROUP   = 2,
   parameter int          OVF_THRESH  = 4,
   parameter int          SPARSE_HI   = 80,
   parameter int          SPARSE_LO   = 50,
   parameter int          CNT_W       = 16,
   parameter int          TIMEOUT     = 1023
) (
   input logic clk,
   input logic rst,
   tile_sequencer_hybrid_if.master bus
);
   localparam int NT_W  = $clog2(MAX_TILES + 1);
   localparam int WS_W  = (WSETS > 1) ? $clog2(WSETS) : 1;
   localparam int AG_W  = (ACC_GROUP > 1) ? $clog2(ACC_GROUP) : 1;
   localparam int OC_W  = $clog2(OVF_THRESH + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int RQ_W  = CNT_W + 8;
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(TILE_STRIDE);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_W,
      S_RD_IN,
      S_START_TILE,
      S_WAIT_TILE,
      S_ADAPT,
      S_WRITE,
      S_NEXT,
      S_DONE,
      S_ERR
   } state_t;

   state_t state;
   state_t nxt;

   logic [NT_W-1:0]   num_r;
   logic [NT_W-1:0]   idx;
   logic [NT_W-1:0]   idx_inc;
   logic [NT_W-1:0]   cfg_clamped;
   logic [WS_W-1:0]   wset;
   logic [WS_W-1:0]   wset_nxt;
   logic [WS_W-1:0]   loaded_set;
   logic [AG_W-1:0]   acc_pos;
   logic [OC_W-1:0]   ovf_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [CNT_W-1:0]  zero_r;
   logic [CNT_W-1:0]  total_r;
   logic              ovf_r;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        prec;
   logic              sparse_en;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              accept;
   logic [RQ_W-1:0]   num;
   logic [RQ_W-1:0]   den;
   logic [RQ_W-1:0]   ratio;

   // done_r is high in the IDLE cycle right after DONE/ERR, so a start there is refused
   assign accept      = (state == S_IDLE) && bus.start && !done_r;
   assign idx_inc     = idx + NT_W'(1);
   assign cfg_clamped = (bus.num_tiles_cfg > NT_W'(MAX_TILES)) ? NT_W'(MAX_TILES)
                                                               : bus.num_tiles_cfg;
   assign wset_nxt    = (wset == WS_W'(WSETS - 1)) ? '0 : wset + WS_W'(1);

   always_comb begin
      num   = RQ_W'(zero_r) * RQ_W'(100);
      den   = RQ_W'(zero_r) + RQ_W'(total_r);
      ratio = (den == '0) ? '0 : num / den;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) nxt = (bus.num_tiles_cfg == '0) ? S_DONE : S_LOAD_W;
         end
         S_LOAD_W: begin
            if (bus.weights_ready) nxt = S_RD_IN;
         end
         S_RD_IN: begin
            if (bus.dram_rd_ready) nxt = S_START_TILE;
         end
         S_START_TILE: nxt = S_WAIT_TILE;
         S_WAIT_TILE: begin
            // a tile_done in the final timeout cycle still completes the tile
            if (bus.tile_done)                          nxt = S_ADAPT;
            else if (tmo_cnt == TMO_W'(TIMEOUT - 1))    nxt = S_ERR;
         end
         S_ADAPT: nxt = S_WRITE;
         S_WRITE: begin
            if (bus.dram_wr_ready) nxt = S_NEXT;
         end
         S_NEXT: begin
            if (idx_inc == num_r)             nxt = S_DONE;
            else if (wset_nxt == loaded_set)  nxt = S_RD_IN;
            else                              nxt = S_LOAD_W;
         end
         S_DONE:  nxt = S_IDLE;
         S_ERR:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.load_weights  = 1'b0;
      bus.dram_rd_en    = 1'b0;
      bus.tile_start    = 1'b0;
      bus.dram_wr_en    = 1'b0;
      bus.accumulate_en = 1'b0;
      case (state)
         S_LOAD_W:     bus.load_weights = 1'b1;
         S_RD_IN:      bus.dram_rd_en   = 1'b1;
         S_START_TILE: bus.tile_start   = 1'b1;
         S_WRITE: begin
            bus.dram_wr_en    = 1'b1;
            bus.accumulate_en = (acc_pos != '0);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_r      <= '0;
         idx        <= '0;
         wset       <= '0;
         loaded_set <= '0;
         acc_pos    <= '0;
         ovf_cnt    <= '0;
         tmo_cnt    <= '0;
         zero_r     <= '0;
         total_r    <= '0;
         ovf_r      <= 1'b0;
         rd_addr    <= '0;
         wr_addr    <= '0;
         prec       <= 2'b10;
         sparse_en  <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         done_r <= (state == S_DONE) || (state == S_ERR);
         case (state)
            S_IDLE: begin
               if (accept) begin
                  num_r   <= cfg_clamped;
                  idx     <= '0;
                  wset    <= '0;
                  acc_pos <= '0;
                  ovf_cnt <= '0;
                  rd_addr <= bus.in_base;
                  wr_addr <= bus.out_base;
                  prec    <= 2'b10;
                  err_r   <= 1'b0;
                  busy_r  <= 1'b1;
               end
            end
            S_LOAD_W: begin
               if (bus.weights_ready) loaded_set <= wset;
            end
            S_START_TILE: tmo_cnt <= '0;
            S_WAIT_TILE: begin
               if (bus.tile_done) begin
                  zero_r  <= bus.zero_ops_skipped;
                  total_r <= bus.total_ops_executed;
                  ovf_r   <= bus.overflow_detected;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            S_ADAPT: begin
               if (ovf_r) begin
                  if (ovf_cnt == OC_W'(OVF_THRESH - 1)) begin
                     ovf_cnt <= '0;
                     prec    <= (prec == 2'b10) ? 2'b01 : 2'b00;
                  end else begin
                     ovf_cnt <= ovf_cnt + OC_W'(1);
                  end
               end
               // between the two thresholds the previous mode is held
               if (ratio >= RQ_W'(SPARSE_HI))     sparse_en <= 1'b1;
               else if (ratio < RQ_W'(SPARSE_LO)) sparse_en <= 1'b0;
            end
            S_NEXT: begin
               idx     <= idx_inc;
               wset    <= wset_nxt;
               rd_addr <= rd_addr + STRIDE;
               if (acc_pos == AG_W'(ACC_GROUP - 1)) begin
                  acc_pos <= '0;
                  wr_addr <= wr_addr + STRIDE;
               end else begin
                  acc_pos <= acc_pos + AG_W'(1);
               end
            end
            S_DONE: busy_r <= 1'b0;
            S_ERR: begin
               busy_r <= 1'b0;
               err_r  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy                 = busy_r;
   assign bus.done                 = done_r;
   assign bus.err_timeout          = err_r;
   assign bus.tiles_completed      = idx;
   assign bus.weight_set           = wset;
   assign bus.dram_rd_addr         = rd_addr;
   assign bus.dram_wr_addr         = wr_addr;
   assign bus.precision_mode       = prec;
   assign bus.sparsity_optimize_en = sparse_en;
endmodule

// File: tb/tb_tile_sequencer_hybrid.sv
// Scoreboard bench for tile_sequencer_hybrid: per-tile expectations are queued at run launch
// and consumed as the DUT performs weight loads, reads and write-backs.
module tb_tile_sequencer_hybrid;
   logic clk = 1'b0;
   logic rst;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tile_sequencer_hybrid_if #(.ADDR_W(32), .MAX_TILES(16), .WSETS(8), .CNT_W(16)) bus ();

   tile_sequencer_hybrid #(
      .ADDR_W(32), .MAX_TILES(16), .TILE_STRIDE(32'h400), .WSETS(8), .ACC_GROUP(2),
      .OVF_THRESH(4), .SPARSE_HI(80), .SPARSE_LO(50), .CNT_W(16), .TIMEOUT(1023)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [31:0] rd;
      logic [31:0] wr;
      logic        acc;
      logic [2:0]  ws;
      logic [1:0]  prec;
      logic        sp;
   } exp_t;

   exp_t exp_q[$];
   int   zq[$];
   int   tq[$];
   int   dq[$];
   bit   oq[$];

   int errors = 0;
   int checks = 0;
   int ts_cnt = 0;
   int rd_cnt = 0;
   int unsigned ts_cyc = 0;
   bit sp_m = 1'b1;
   int rdy_mode = 0;
   bit prev_ts, prev_lw, prev_rd, prev_wr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  bus.busy, 0);
      check({tag, "_done"},  bus.done, 0);
      check({tag, "_err"},   bus.err_timeout, 0);
      check({tag, "_lw"},    bus.load_weights, 0);
      check({tag, "_rden"},  bus.dram_rd_en, 0);
      check({tag, "_wren"},  bus.dram_wr_en, 0);
      check({tag, "_ts"},    bus.tile_start, 0);
      check({tag, "_acc"},   bus.accumulate_en, 0);
      check({tag, "_rdadr"}, bus.dram_rd_addr, 0);
      check({tag, "_wradr"}, bus.dram_wr_addr, 0);
      check({tag, "_ws"},    bus.weight_set, 0);
      check({tag, "_tc"},    bus.tiles_completed, 0);
      check({tag, "_prec"},  bus.precision_mode, 2'b10);
      check({tag, "_sp"},    bus.sparsity_optimize_en, 1);
   endtask

   // readies change just after the active edge so negedge sampling sees stable values
   initial begin
      bus.weights_ready = 1'b0;
      bus.dram_rd_ready = 1'b0;
      bus.dram_wr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) begin
            bus.weights_ready = 1'b1;
            bus.dram_rd_ready = 1'b1;
            bus.dram_wr_ready = 1'b1;
         end else begin
            bus.weights_ready = 1'($urandom_range(0, 1));
            bus.dram_rd_ready = 1'($urandom_range(0, 1));
            bus.dram_wr_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // tile engine model: answers each tile_start from the response queues
   initial begin
      int z, t, d;
      bit o;
      bus.tile_done          = 1'b0;
      bus.zero_ops_skipped   = '0;
      bus.total_ops_executed = '0;
      bus.overflow_detected  = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tile_start && zq.size() > 0) begin
            z = zq.pop_front();
            t = tq.pop_front();
            o = oq.pop_front();
            d = dq.pop_front();
            if (d >= 0) begin
               repeat (d + 1) @(negedge clk);
               bus.tile_done          = 1'b1;
               bus.zero_ops_skipped   = 16'(z);
               bus.total_ops_executed = 16'(t);
               bus.overflow_detected  = o;
               @(negedge clk);
               bus.tile_done = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         prev_ts = 0;
         prev_lw = 0;
         prev_rd = 0;
         prev_wr = 0;
      end else begin
         if (prev_lw) check("lw_hold", bus.load_weights, 1);
         if (prev_rd) check("rd_hold", bus.dram_rd_en, 1);
         if (prev_wr) check("wr_hold", bus.dram_wr_en, 1);
         if (bus.tile_start) begin
            check("ts_width", prev_ts, 0);
            ts_cnt++;
            ts_cyc = cyc;
         end
         if (bus.accumulate_en) check("acc_qual", bus.dram_wr_en, 1);
         if (bus.load_weights && bus.weights_ready) begin
            check("sb_lw", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("wset", bus.weight_set, exp_q[0].ws);
         end
         if (bus.dram_rd_en && bus.dram_rd_ready) begin
            rd_cnt++;
            check("sb_rd", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("rd_addr", bus.dram_rd_addr, exp_q[0].rd);
         end
         if (bus.dram_wr_en && bus.dram_wr_ready) begin
            check("sb_wr", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("wr_addr", bus.dram_wr_addr, exp_q[0].wr);
               check("acc_en", bus.accumulate_en, exp_q[0].acc);
               check("prec", bus.precision_mode, exp_q[0].prec);
               check("sparse", bus.sparsity_optimize_en, exp_q[0].sp);
               void'(exp_q.pop_front());
            end
         end
         prev_ts = bus.tile_start;
         prev_lw = bus.load_weights && !bus.weights_ready;
         prev_rd = bus.dram_rd_en && !bus.dram_rd_ready;
         prev_wr = bus.dram_wr_en && !bus.dram_wr_ready;
      end
   end

   // prof: 0 low sparsity, 1 all overflow, 2 sparsity sequence, 3 random; dly<0 withholds tile_done
   task automatic run(input int cfg, input logic [31:0] inb, input logic [31:0] outb,
                      input int prof, input int dly, input bit exp_err, input bit timed,
                      input bit poke);
      int sz[6] = '{90, 60, 40, 60, 85, 0};
      int st[6] = '{10, 40, 60, 40, 15, 0};
      int n, z, t, oc, ratio, ts0, rd0;
      bit o, seen;
      logic [1:0] pm;
      exp_t e;
      int unsigned c0, cd;
      n  = (cfg > 16) ? 16 : cfg;
      oc = 0;
      pm = 2'b10;
      for (int i = 0; i < n; i++) begin
         case (prof)
            1:       begin z = 0;       t = 10;      o = 1; end
            2:       begin z = sz[i%6]; t = st[i%6]; o = 0; end
            3:       begin z = $urandom_range(0, 200); t = $urandom_range(0, 200);
                           o = 1'($urandom_range(0, 1)); end
            default: begin z = 3;       t = 7;       o = 0; end
         endcase
         zq.push_back(z);
         tq.push_back(t);
         oq.push_back(o);
         dq.push_back(dly);
         if (dly >= 0) begin
            if (o) begin
               oc++;
               if (oc == 4) begin
                  pm = (pm == 2'b10) ? 2'b01 : 2'b00;
                  oc = 0;
               end
            end
            ratio = (z + t == 0) ? 0 : (z * 100) / (z + t);
            if (ratio >= 80)     sp_m = 1'b1;
            else if (ratio < 50) sp_m = 1'b0;
         end
         e.rd   = inb + i * 32'h400;
         e.wr   = outb + (i / 2) * 32'h400;
         e.acc  = (i % 2) != 0;
         e.ws   = 3'(i % 8);
         e.prec = pm;
         e.sp   = sp_m;
         exp_q.push_back(e);
      end
      ts0 = ts_cnt;
      rd0 = rd_cnt;
      bus.num_tiles_cfg = 5'(cfg);
      bus.in_base       = inb;
      bus.out_base      = outb;
      bus.start         = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy", bus.busy, 1);
      check("err_clr", bus.err_timeout, 0);
      seen = 0;
      for (int k = 0; k < 3000; k++) begin
         if (bus.done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      cd = cyc;
      check("done_seen", seen, 1);
      if (seen) begin
         check("tiles_done", bus.tiles_completed, exp_err ? 0 : n);
         check("err_flag", bus.err_timeout, exp_err);
         check("busy_end", bus.busy, 0);
         check("tiles_started", ts_cnt - ts0, n);
         check("reads", rd_cnt - rd0, n);
         if (timed)   check("latency", cd - c0, 7 * n + 2);
         if (exp_err) check("tmo_latency", cd - ts_cyc, 1025);
         if (poke) bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         check("done_width", bus.done, 0);
         if (poke) check("poke_ignored", bus.busy, 0);
      end
      if (exp_err || !seen) begin
         exp_q.delete();
         zq.delete(); tq.delete(); oq.delete(); dq.delete();
      end
      check("sb_empty", exp_q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int ts0;
      exp_t e;
      rst = 1'b1;
      bus.start         = 1'b0;
      bus.num_tiles_cfg = '0;
      bus.in_base       = '0;
      bus.out_base      = '0;
      repeat (3) @(negedge clk);
      check_idle("rst");
      rst = 1'b0;
      @(negedge clk);

      run(3, 32'h1000, 32'h8000, 0, 0, 0, 1, 0);
      run(5, 32'h2000, 32'h9000, 1, 0, 0, 1, 0);
      run(6, 32'h0,    32'h4000, 2, 0, 0, 1, 0);
      run(0, 32'h1000, 32'h8000, 0, 0, 0, 1, 0);
      run(20, 32'h10000, 32'h20000, 0, 0, 0, 1, 0);
      run(1, 32'h3000, 32'h7000, 0, -1, 1, 0, 0);
      run(1, 32'h3000, 32'h7000, 2, 1022, 0, 0, 1);
      rdy_mode = 1;
      run(8, 32'h5000, 32'hA000, 3, 3, 0, 0, 0);
      rdy_mode = 0;
      repeat (2) @(negedge clk);

      // reset in WAIT_TILE after a start pulse that is refused because the run is busy
      e.rd = 32'h2000; e.wr = 32'h3000; e.acc = 0; e.ws = 0; e.prec = 2'b10; e.sp = sp_m;
      exp_q.push_back(e);
      ts0 = ts_cnt;
      bus.num_tiles_cfg = 5'd2;
      bus.in_base       = 32'h2000;
      bus.out_base      = 32'h3000;
      bus.start         = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 50 && ts_cnt == ts0; k++) @(negedge clk);
      check("rt_started", ts_cnt - ts0, 1);
      repeat (3) @(negedge clk);
      check("rt_busy", bus.busy, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("rt_busy2", bus.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check_idle("mid_rst");
      rst = 1'b0;
      exp_q.delete();
      zq.delete(); tq.delete(); oq.delete(); dq.delete();
      sp_m = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_busy", bus.busy, 0);
         check("post_rst_lw", bus.load_weights, 0);
      end

      run(2, 32'h4000, 32'h5000, 0, 0, 0, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
